tx_unpacker_ge: RTL and testbench

DSP-side reader for the tagged 18-bit sample stream produced by the GE receive buffer format (bit 17 = channel-0 tag, bit 16 = I/Q tag, bits 15:0 = sample). It pops words from a show-ahead FIFO once per `txstrobe` and reassembles one frame of `channels` samples into eight parallel channel registers. It uses the channel-0 tag to detect misalignment and recover from it, and reports underruns.

---
 rtl/tx_unpacker_ge.sv | 149 ++++++++++++++
 tb/tb_tx_unpacker_ge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_unpacker_ge.sv
// tx_unpacker_ge: pops tagged 18-bit words from a show-ahead FIFO once per txstrobe,
// realigns on the channel-0 tag and presents a frame of up to eight 16-bit samples.
module tx_unpacker_ge #(
    parameter int MAXCH = 8
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        gate_enable,
    input  logic        txstrobe,
    input  logic [3:0]  channels,
    input  logic [17:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic        clear_status,
    output logic [15:0] ch_0,
    output logic [15:0] ch_1,
    output logic [15:0] ch_2,
    output logic [15:0] ch_3,
    output logic [15:0] ch_4,
    output logic [15:0] ch_5,
    output logic [15:0] ch_6,
    output logic [15:0] ch_7,
    output logic        frame_valid,
    output logic        underrun,
    output logic [7:0]  resync_count,
    output logic [15:0] debugbus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HUNT = 2'd2;

    logic [1:0]  state;
    logic [3:0]  phase;
    logic [3:0]  num_ch;
    logic [15:0] stg    [MAXCH];
    logic [15:0] ch_reg [MAXCH];
    logic        tag0;
    logic        head_valid;
    logic        misaligned;
    logic        frame_broken;
    logic        resync_event;
    logic        last_word;
    logic [2:0]  stg_idx;
    logic        iq_tag_unused;

    always_comb begin
        num_ch = (channels > 4'(MAXCH)) ? 4'(MAXCH) : channels;
    end

    assign tag0          = fifo_q[17];
    assign iq_tag_unused = fifo_q[16];
    assign head_valid    = !fifo_empty;
    assign misaligned    = (state == ST_LOAD) && head_valid && (phase == 4'd1) && !tag0;
    assign frame_broken  = (state == ST_LOAD) && head_valid && (phase > 4'd1) && tag0;
    assign resync_event  = misaligned || frame_broken;
    assign last_word     = (phase == num_ch);
    assign stg_idx       = 3'(phase - 4'd1);

    // A broken frame leaves the tagged head in place so it can start the next frame.
    assign fifo_rdreq = !reset && head_valid &&
                        (((state == ST_LOAD) && !((phase > 4'd1) && tag0)) ||
                         ((state == ST_HUNT) && !tag0));

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase       <= 4'd0;
            frame_valid <= 1'b0;
            for (int k = 0; k < MAXCH; k++) begin
                stg[k]    <= '0;
                ch_reg[k] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (txstrobe && gate_enable && (num_ch != 4'd0)) begin
                        state <= ST_LOAD;
                        phase <= 4'd1;
                    end
                end
                ST_LOAD: begin
                    if (head_valid) begin
                        if (misaligned) begin
                            state <= ST_HUNT;
                        end else if (frame_broken) begin
                            phase <= 4'd1;
                        end else begin
                            stg[stg_idx] <= fifo_q[15:0];
                            if (last_word) begin
                                // The final word bypasses staging so the frame lands in one edge.
                                for (int k = 0; k < MAXCH; k++) begin
                                    if (k < int'(num_ch) - 1)
                                        ch_reg[k] <= stg[k];
                                    else if (k == int'(num_ch) - 1)
                                        ch_reg[k] <= fifo_q[15:0];
                                    else
                                        ch_reg[k] <= '0;
                                end
                                frame_valid <= 1'b1;
                                state       <= ST_IDLE;
                                phase       <= 4'd0;
                            end else begin
                                phase <= phase + 4'd1;
                            end
                        end
                    end
                end
                ST_HUNT: begin
                    if (head_valid && tag0) begin
                        state <= ST_LOAD;
                        phase <= 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky status: a set in the same cycle as a clear wins.
    always_ff @(posedge rxclk) begin
        if (reset) begin
            underrun     <= 1'b0;
            resync_count <= 8'd0;
        end else begin
            if (txstrobe && (state != ST_IDLE))
                underrun <= 1'b1;
            else if (clear_status)
                underrun <= 1'b0;

            if (clear_status)
                resync_count <= resync_event ? 8'd1 : 8'd0;
            else if (resync_event && (resync_count != 8'hFF))
                resync_count <= resync_count + 8'd1;
        end
    end

    assign ch_0 = ch_reg[0];
    assign ch_1 = ch_reg[1];
    assign ch_2 = ch_reg[2];
    assign ch_3 = ch_reg[3];
    assign ch_4 = ch_reg[4];
    assign ch_5 = ch_reg[5];
    assign ch_6 = ch_reg[6];
    assign ch_7 = ch_reg[7];

    assign debugbus = {5'b0, fifo_q[17], underrun, txstrobe, fifo_rdreq, fifo_empty, phase, state};

endmodule

// File: tb/tb_tx_unpacker_ge.sv
// tb_tx_unpacker_ge: drives tx_unpacker_ge from a queue-backed show-ahead FIFO and
// compares every cycle against a word-consumer model built from queues.
module tb_tx_unpacker_ge;
    logic        rxclk = 1'b0;
    logic        reset;
    logic        gate_enable;
    logic        txstrobe;
    logic [3:0]  channels;
    logic [17:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        clear_status;
    logic [15:0] ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
    logic        frame_valid;
    logic        underrun;
    logic [7:0]  resync_count;
    logic [15:0] debugbus;
    logic [15:0] dut_ch [8];

    always #5 rxclk = ~rxclk;

    tx_unpacker_ge #(.MAXCH(8)) dut (
        .rxclk(rxclk), .reset(reset), .gate_enable(gate_enable), .txstrobe(txstrobe),
        .channels(channels), .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
        .clear_status(clear_status),
        .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
        .ch_4(ch_4), .ch_5(ch_5), .ch_6(ch_6), .ch_7(ch_7),
        .frame_valid(frame_valid), .underrun(underrun), .resync_count(resync_count),
        .debugbus(debugbus)
    );

    assign dut_ch[0] = ch_0;
    assign dut_ch[1] = ch_1;
    assign dut_ch[2] = ch_2;
    assign dut_ch[3] = ch_3;
    assign dut_ch[4] = ch_4;
    assign dut_ch[5] = ch_5;
    assign dut_ch[6] = ch_6;
    assign dut_ch[7] = ch_7;

    logic [17:0] fifo [$];
    int checks = 0;
    int failures = 0;

    // Model: busy means a frame is owed; collected words wait in m_coll until N arrive.
    logic        m_busy = 1'b0;
    logic        m_hunt = 1'b0;
    logic [15:0] m_coll [$];
    logic [15:0] m_ch [8];
    logic        m_fv = 1'b0;
    logic        m_under = 1'b0;
    int          m_resync = 0;

    logic        cur_gate = 1'b1;
    logic [3:0]  cur_ch = 4'd2;
    int          cyc = 0;
    int          pops = 0;
    int          frames = 0;
    int          first_pop_cyc = -1;
    int          fv_cyc = -1;
    int          strobe_cyc = 0;
    int          wpos = 0;

    function automatic int clamp_n(input logic [3:0] c);
        return (c > 4'd8) ? 8 : int'(c);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic model_pop();
        logic tag;
        if (reset || !m_busy || fifo.size() == 0) return 1'b0;
        tag = fifo[0][17];
        if (m_hunt) return !tag;
        return !((m_coll.size() > 0) && tag);
    endfunction

    task automatic model_step();
        int n;
        logic tag;
        logic inc;
        logic under_set;
        if (reset) begin
            m_busy = 1'b0; m_hunt = 1'b0; m_coll.delete(); m_fv = 1'b0;
            m_under = 1'b0; m_resync = 0;
            for (int k = 0; k < 8; k++) m_ch[k] = '0;
            return;
        end
        n = clamp_n(channels);
        m_fv = 1'b0;
        inc = 1'b0;
        under_set = txstrobe && m_busy;
        if (!m_busy) begin
            if (txstrobe && gate_enable && n != 0) begin
                m_busy = 1'b1; m_hunt = 1'b0; m_coll.delete();
            end
        end else if (fifo.size() != 0) begin
            tag = fifo[0][17];
            if (m_hunt) begin
                if (tag) m_hunt = 1'b0;
            end else if (m_coll.size() == 0 && !tag) begin
                m_hunt = 1'b1; inc = 1'b1;
            end else if (m_coll.size() > 0 && tag) begin
                m_coll.delete(); inc = 1'b1;
            end else begin
                m_coll.push_back(fifo[0][15:0]);
                if (m_coll.size() == n) begin
                    for (int k = 0; k < 8; k++) m_ch[k] = (k < n) ? m_coll[k] : 16'h0;
                    m_fv = 1'b1; m_busy = 1'b0;
                end
            end
        end
        if (clear_status) begin m_under = 1'b0; m_resync = 0; end
        if (under_set) m_under = 1'b1;
        if (inc && m_resync < 255) m_resync++;
    endtask

    // One clock cycle: drive inputs, check the combinational pop, clock, check registered outputs.
    task automatic applyStimulus(input logic rst, input logic strobe, input logic clr);
        logic exp_pop;
        logic dut_pop;
        reset = rst; gate_enable = cur_gate; txstrobe = strobe; clear_status = clr; channels = cur_ch;
        fifo_empty = (fifo.size() == 0);
        fifo_q = (fifo.size() != 0) ? fifo[0] : 18'($urandom);
        #4;
        exp_pop = model_pop();
        checkOutput("fifo_rdreq", {31'b0, fifo_rdreq}, {31'b0, exp_pop});
        if (!rst)
            checkOutput("debugbus_hi", {22'b0, debugbus[15:6]},
                        {22'b0, 5'b0, fifo_q[17], m_under, txstrobe, exp_pop, fifo_empty});
        dut_pop = fifo_rdreq;
        @(posedge rxclk);
        model_step();
        if (dut_pop && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        #1;
        checkOutput("frame_valid", {31'b0, frame_valid}, {31'b0, m_fv});
        checkOutput("underrun", {31'b0, underrun}, {31'b0, m_under});
        checkOutput("resync_count", {24'b0, resync_count}, m_resync);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("ch_%0d", k), {16'b0, dut_ch[k]}, {16'b0, m_ch[k]});
        if (frame_valid === 1'b1) begin
            frames++;
            fv_cyc = cyc + 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe_now();
        strobe_cyc = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_frame(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) fifo.push_back({(i == 0), 1'b0, base + 16'(i)});
    endtask

    initial begin
        for (int k = 0; k < 8; k++) m_ch[k] = '0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        idle(1);
        checkOutput("reset ch_0", {16'b0, ch_0}, 32'h0);
        checkOutput("reset resync", {24'b0, resync_count}, 32'h0);
        checkOutput("reset rdreq", {31'b0, fifo_rdreq}, 32'h0);

        // Basic frame
        cur_ch = 4'd2; pops = 0; frames = 0; first_pop_cyc = -1; fv_cyc = -1;
        fifo.push_back({2'b10, 16'h1111});
        fifo.push_back({2'b01, 16'h2222});
        strobe_now();
        idle(5);
        checkOutput("basic pops", pops, 2);
        checkOutput("basic frames", frames, 1);
        checkOutput("basic first pop cycle", first_pop_cyc - strobe_cyc, 1);
        checkOutput("basic frame_valid cycle", fv_cyc - strobe_cyc, 3);
        checkOutput("basic ch_0", {16'b0, ch_0}, 32'h1111);
        checkOutput("basic ch_1", {16'b0, ch_1}, 32'h2222);
        checkOutput("basic ch_2", {16'b0, ch_2}, 32'h0);

        // Misalignment recovery
        pops = 0;
        fifo.push_back({2'b01, 16'hAAAA});
        fifo.push_back({2'b10, 16'h0001});
        fifo.push_back({2'b01, 16'h0002});
        strobe_now();
        idle(7);
        checkOutput("misalign pops", pops, 3);
        checkOutput("misalign resync", {24'b0, resync_count}, 1);
        checkOutput("misalign ch_0", {16'b0, ch_0}, 32'h0001);
        checkOutput("misalign ch_1", {16'b0, ch_1}, 32'h0002);

        // Short frame, with a status clear landing on the realignment cycle
        cur_ch = 4'd4; pops = 0; frames = 0;
        fifo.push_back({2'b10, 16'h0010});
        fifo.push_back({2'b00, 16'h0011});
        fifo.push_back({2'b10, 16'h0020});
        fifo.push_back({2'b00, 16'h0021});
        fifo.push_back({2'b00, 16'h0022});
        fifo.push_back({2'b00, 16'h0023});
        strobe_now();
        idle(2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        idle(8);
        checkOutput("short pops", pops, 6);
        checkOutput("short frames", frames, 1);
        checkOutput("short resync set-wins", {24'b0, resync_count}, 1);
        checkOutput("short ch_0", {16'b0, ch_0}, 32'h20);
        checkOutput("short ch_3", {16'b0, ch_3}, 32'h23);
        checkOutput("short ch_4", {16'b0, ch_4}, 32'h0);

        // Underrun and stall; second strobe carries a clear, the set must win
        cur_ch = 4'd8; frames = 0;
        strobe_now();
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("underrun set-wins", {31'b0, underrun}, 1);
        push_frame(8, 16'h0300);
        idle(14);
        checkOutput("underrun frames", frames, 1);
        checkOutput("underrun ch_7", {16'b0, ch_7}, 32'h0307);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("underrun cleared", {31'b0, underrun}, 0);

        // Gating and clamp
        cur_gate = 1'b0; cur_ch = 4'd2; pops = 0; frames = 0;
        push_frame(2, 16'h0400);
        strobe_now();
        idle(5);
        checkOutput("gated pops", pops, 0);
        checkOutput("gated frames", frames, 0);
        cur_gate = 1'b1; cur_ch = 4'd0;
        strobe_now();
        idle(5);
        checkOutput("zero-channel pops", pops, 0);
        cur_ch = 4'd12;
        for (int i = 0; i < 6; i++) fifo.push_back({2'b00, 16'h0402 + 16'(i)});
        push_frame(8, 16'h0500);
        strobe_now();
        idle(12);
        checkOutput("clamp pops", pops, 8);
        checkOutput("clamp frames", frames, 1);
        checkOutput("clamp ch_7", {16'b0, ch_7}, 32'h0407);
        strobe_now();
        idle(12);
        checkOutput("clamp pops second", pops, 16);

        // Reset mid-frame
        cur_ch = 4'd8; pops = 0; frames = 0;
        push_frame(8, 16'h0600);
        strobe_now();
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("midreset pops", pops, 3);
        checkOutput("midreset ch_0", {16'b0, ch_0}, 32'h0);
        fifo.delete();
        idle(2);
        push_frame(8, 16'h0700);
        strobe_now();
        idle(12);
        checkOutput("postreset frames", frames, 1);
        checkOutput("postreset ch_0", {16'b0, ch_0}, 32'h0700);
        checkOutput("postreset ch_7", {16'b0, ch_7}, 32'h0707);

        // Saturation: every second word breaks a two-word frame
        cur_ch = 4'd2;
        for (int i = 0; i < 300; i++) fifo.push_back({2'b10, 16'(i)});
        strobe_now();
        idle(640);
        checkOutput("resync saturated", {24'b0, resync_count}, 255);
        applyStimulus(1'b1, 1'b0, 1'b0);
        fifo.delete();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            if (fifo.size() < 24 && ($urandom % 3) == 0) begin
                fifo.push_back({((wpos == 0) ^ (($urandom % 16) == 0)), 1'($urandom), 16'($urandom)});
                wpos = (wpos + 1) % ((clamp_n(cur_ch) == 0) ? 1 : clamp_n(cur_ch));
            end
            if (!m_busy && ($urandom % 40) == 0) begin
                cur_ch = 4'($urandom);
                cur_gate = 1'b0;
            end else if (!cur_gate && ($urandom % 10) == 0) begin
                cur_gate = 1'b1;
            end else if (cur_gate && ($urandom % 80) == 0) begin
                cur_gate = 1'b0;
            end
            applyStimulus(($urandom % 500) == 0, ($urandom % 6) == 0, ($urandom % 30) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
